// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the 640x480@60 VGA pipeline.
// Rev 1.0
`default_nettype none

package vga_pkg;

  // Sync generator timing, in pixel clocks / lines
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Framebuffer geometry
  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int SCALE     = 4;
  localparam int FB_ADDR_W = 15;
  localparam int RGB_W     = 12;
  localparam int LAST_ROW_BASE = 19040;

  typedef enum logic [0:0] {
    UNSYNC = 1'b0,
    RUN    = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

  function automatic int row_base_max(input int w, input int h);
    return w * (h - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_fb_scan_if.sv
// vga_fb_scan_if: framebuffer RAM read port between scan-out and RAM.
// Rev 1.0
`default_nettype none

interface vga_fb_scan_if;
  import vga_pkg::*;

  logic                 ram_en;
  logic [FB_ADDR_W-1:0] ram_addr;
  logic [RGB_W-1:0]     ram_data;

  modport master (output ram_en, output ram_addr, input ram_data);
  modport slave  (input ram_en, input ram_addr, output ram_data);

endinterface

`default_nettype wire

// File: rtl/vga_fb_scan_sync_delay.sv
// sync_delay: DEPTH-stage shift register of {hsync, vsync, de}, reset to idle.
// Rev 1.0
`default_nettype none

module sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic      clock,
  input  wire logic      reset_n,
  input  wire sync_bus_t d,
  output sync_bus_t      q
);

  sync_bus_t stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_fb_scan.sv
// vga_fb_scan: framebuffer scan-out with 4x4 pixel replication and aligned syncs.
// Rev 1.0
`default_nettype none

module vga_fb_scan
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int FB_W   = vga_pkg::FB_W,
  parameter int FB_H   = vga_pkg::FB_H,
  parameter int SCALE  = vga_pkg::SCALE
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  input  wire logic         hsync_i,
  input  wire logic         vsync_i,
  input  wire logic         de_i,
  vga_fb_scan_if.master     ram,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic [RGB_W-1:0]  rgb_o,
  output logic              frame_start
);

  localparam logic [1:0]           SUB_MAX  = 2'(SCALE - 1);
  localparam logic [7:0]           X_MAX    = 8'(FB_W - 1);
  localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(FB_W);
  localparam logic [FB_ADDR_W-1:0] ROW_MAX  = FB_ADDR_W'(row_base_max(FB_W, FB_H));

  scan_state_t          state;
  logic                 vsync_q;
  logic                 de_q;
  logic [1:0]           x_sub;
  logic [7:0]           x_addr;
  logic [1:0]           y_sub;
  logic [FB_ADDR_W-1:0] row_base;
  logic                 en_tap;
  logic [RGB_W-1:0]     rgb_q;
  sync_bus_t            sync_out;

  logic vs_fall;
  logic de_fall;

  assign vs_fall = vsync_q & ~vsync_i;
  assign de_fall = de_q & ~de_i;

  assign ram.ram_en   = (state == RUN) & de_i;
  assign ram.ram_addr = row_base + FB_ADDR_W'(x_addr);

  // vsync_q resets low so a reset released during the vsync pulse is not seen as a fall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= UNSYNC;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      x_sub       <= '0;
      x_addr      <= '0;
      y_sub       <= '0;
      row_base    <= '0;
      frame_start <= 1'b0;
    end else begin
      vsync_q     <= vsync_i;
      de_q        <= de_i;
      frame_start <= vs_fall;
      if (vs_fall) begin
        state    <= RUN;
        x_sub    <= '0;
        x_addr   <= '0;
        y_sub    <= '0;
        row_base <= '0;
      end else if (state == RUN) begin
        if (de_fall) begin
          x_sub  <= '0;
          x_addr <= '0;
          if (y_sub == SUB_MAX) begin
            y_sub <= '0;
            if (row_base != ROW_MAX) row_base <= row_base + ROW_STEP;
          end else begin
            y_sub <= y_sub + 2'd1;
          end
        end else if (de_i) begin
          if (x_sub == SUB_MAX) begin
            x_sub <= '0;
            if (x_addr != X_MAX) x_addr <= x_addr + 8'd1;
          end else begin
            x_sub <= x_sub + 2'd1;
          end
        end
      end
    end
  end

  // Read-enable delayed to the cycle in which its data is on ram_data
  generate
    if (RD_LAT == 1) begin : g_lat1
      logic en_d;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) en_d <= 1'b0;
        else          en_d <= ram.ram_en;
      end
      assign en_tap = en_d;
    end else begin : g_latn
      logic [RD_LAT-1:0] en_pipe;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) en_pipe <= '0;
        else          en_pipe <= {en_pipe[RD_LAT-2:0], ram.ram_en};
      end
      assign en_tap = en_pipe[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rgb_q <= '0;
    else          rgb_q <= en_tap ? ram.ram_data : '0;
  end

  sync_delay #(
    .DEPTH (RD_LAT + 1)
  ) u_sync_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ('{hsync: hsync_i, vsync: vsync_i, de: de_i}),
    .q       (sync_out)
  );

  assign hsync_o = sync_out.hsync;
  assign vsync_o = sync_out.vsync;
  assign de_o    = sync_out.de;
  assign rgb_o   = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_scan.sv
// tb_vga_fb_scan: directed bench driving RD_LAT=1 and RD_LAT=2 instances side by side.
// Rev 1.0
`default_nettype none

module tb_vga_fb_scan;
  import vga_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic force_fff = 1'b1;

  always #20 clock = ~clock;

  vga_fb_scan_if bus1();
  vga_fb_scan_if bus2();

  logic        hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
  logic [11:0] rgb1, rgb2;
  logic [11:0] rd1, rd2a, rd2;

  vga_fb_scan #(.RD_LAT(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .hsync_i(hs), .vsync_i(vs), .de_i(de),
    .ram(bus1), .hsync_o(hs1), .vsync_o(vs1), .de_o(de1), .rgb_o(rgb1), .frame_start(fs1)
  );

  vga_fb_scan #(.RD_LAT(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .hsync_i(hs), .vsync_i(vs), .de_i(de),
    .ram(bus2), .hsync_o(hs2), .vsync_o(vs2), .de_o(de2), .rgb_o(rgb2), .frame_start(fs2)
  );

  // RAM models: data = addr[11:0], or all-ones while force_fff is set
  always @(posedge clock) begin
    if (bus1.ram_en) rd1 <= bus1.ram_addr[11:0];
    if (bus2.ram_en) rd2a <= bus2.ram_addr[11:0];
    rd2 <= rd2a;
  end
  assign bus1.ram_data = force_fff ? 12'hFFF : rd1;
  assign bus2.ram_data = force_fff ? 12'hFFF : rd2;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic h, input logic v, input logic d);
    @(posedge clock);
    #1;
    hs = h; vs = v; de = d;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_hs1"}, hs1, 1);
    chk({tag, "_vs1"}, vs1, 1);
    chk({tag, "_de1"}, de1, 0);
    chk({tag, "_rgb1"}, rgb1, 0);
    chk({tag, "_en1"}, bus1.ram_en, 0);
    chk({tag, "_fs1"}, fs1, 0);
    chk({tag, "_hs2"}, hs2, 1);
    chk({tag, "_de2"}, de2, 0);
    chk({tag, "_rgb2"}, rgb2, 0);
    chk({tag, "_en2"}, bus2.ram_en, 0);
  endtask

  function automatic bit hs_at(input int j, input int act);
    return (j >= act + 4 && j < act + 12) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [11:0] exp_rgb(input int j, input int act, input int base, input bit en);
    int x;
    if (!en || j < 0 || j >= act) return 12'h000;
    if (force_fff) return 12'hFFF;
    x = j / 4;
    if (x > 159) x = 159;
    return 12'((base + x) & 12'hFFF);
  endfunction

  // One line: act active cycles then blank cycles with an 8-cycle hsync pulse
  task automatic run_line(input int act, input int blank, input int base, input bit en_exp);
    for (int k = 0; k < act + blank; k++) begin
      cyc(hs_at(k, act), 1'b1, k < act);
      if (k < act) begin
        chk("ram_en1", bus1.ram_en, en_exp);
        chk("ram_en2", bus2.ram_en, en_exp);
        if (en_exp) begin
          int x;
          x = k / 4;
          if (x > 159) x = 159;
          chk("addr1", bus1.ram_addr, base + x);
          chk("addr2", bus2.ram_addr, base + x);
        end
      end else begin
        chk("ram_en_blank", bus1.ram_en, 0);
      end
      chk("de_o1", de1, (k >= 2 && k < act + 2));
      chk("de_o2", de2, (k >= 3 && k < act + 3));
      chk("hs_o1", hs1, hs_at(k - 2, act));
      chk("hs_o2", hs2, hs_at(k - 3, act));
      chk("vs_o1", vs1, 1);
      chk("fs1_low", fs1, 0);
      chk("rgb1", rgb1, exp_rgb(k - 2, act, base, en_exp));
      chk("rgb2", rgb2, exp_rgb(k - 3, act, base, en_exp));
    end
  endtask

  task automatic vsync_pulse();
    idle(4);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("fs1", fs1, k == 1);
      chk("fs2", fs2, k == 1);
      chk("vs_fall_o1", vs1, k < 2);
      chk("vs_fall_o2", vs2, k < 3);
      chk("vs_rgb1", rgb1, 0);
      chk("vs_rgb2", rgb2, 0);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk("fs1_after", fs1, 0);
      chk("vs_rise_o1", vs1, k >= 2);
      chk("vs_rise_o2", vs2, k >= 3);
    end
  endtask

  initial begin
    // Reset held while inputs wiggle, RAM data forced high
    for (int k = 0; k < 6; k++) begin
      cyc(k[0], k[1], 1'b1);
      chk_idle_outputs("reset");
    end

    // Release mid-line during the vsync pulse: no false frame start, stays blank
    @(posedge clock);
    #1;
    reset_n = 1'b1; hs = 1'b1; vs = 1'b0; de = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, 1'b1);
      chk("unsync_en1", bus1.ram_en, 0);
      chk("unsync_rgb1", rgb1, 0);
      chk("unsync_rgb2", rgb2, 0);
      chk("unsync_fs1", fs1, 0);
    end
    idle(4);
    run_line(8, 16, 0, 1'b0);
    run_line(8, 16, 0, 1'b0);

    // First frame, including an overlong 490-line frame and x saturation on line 1
    vsync_pulse();
    force_fff = 1'b0;
    idle(4);
    for (int l = 0; l < 490; l++) begin
      int act, base;
      act  = (l < 5 || l == 479 || l == 489) ? 640 : 4;
      if (l == 1) act = 648;
      base = ((l / 4) > 119 ? 119 : (l / 4)) * 160;
      if (l == 488) force_fff = 1'b1;
      run_line(act, (act >= 640) ? 20 : 16, base, 1'b1);
    end

    // Blanking with forced RAM data across the vsync lines
    vsync_pulse();
    force_fff = 1'b0;

    // Vsync fall coincides with de fall at the end of line 3: no row advance
    run_line(4, 16, 0, 1'b1);
    run_line(4, 16, 0, 1'b1);
    run_line(4, 16, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk("prio_addr1", bus1.ram_addr, 0);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("prio_fs1", fs1, k == 1);
    end
    idle(11);
    run_line(4, 16, 0, 1'b1);
    run_line(4, 16, 0, 1'b1);
    run_line(4, 16, 0, 1'b1);
    run_line(4, 16, 0, 1'b1);
    run_line(4, 16, 160, 1'b1);

    // Asynchronous reset in the middle of an active line
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b1, 1'b1);
      chk("pre_rst_en1", bus1.ram_en, 1);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    reset_n = 1'b1; de = 1'b0;
    @(negedge clock);
    idle(4);
    run_line(8, 16, 0, 1'b0);
    vsync_pulse();
    idle(2);
    run_line(8, 16, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
